// File: rtl/pipe_control.sv
// Pipelined control for the filter processor: decodes in ID and carries registered
// control through EX, MEM and WB with load-use stalls, MUL holds and branch flush.
module pipe_control #(
  parameter int REG_AW  = 4,
  parameter int ALU_W   = 6,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        opcode,
  input  logic [1:0]        cmp_flag,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              cmp_result,
  output logic              id_ready,
  output logic              re_a,
  output logic              re_b,
  output logic              ex_valid,
  output logic [ALU_W-1:0]  ex_alu_ctrl,
  output logic [1:0]        ex_sel_b,
  output logic              ex_alu_mux,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_we,
  output logic              mem_re,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_reg_we,
  output logic              wb_sel_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              branch_taken,
  output logic              flag_q
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic [1:0]       sel_b;
    logic             alu_mux;
    logic             mem_we;
    logic             mem_re;
    logic             reg_we;
    logic             sel_data;
    logic             is_ld;
    logic             is_cmp;
    logic             is_bt;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [3:0] op, input logic [1:0] flag);
    ctrl_t c;
    c        = '0;
    c.reg_we = 1'b1;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: c.alu_ctrl = ALU_W'(op);
      4'd8: begin
        c.is_cmp = 1'b1;
        c.reg_we = 1'b0;
        case (flag)
          2'b01:   c.alu_ctrl = ALU_W'(8);
          2'b10:   c.alu_ctrl = ALU_W'(9);
          2'b11:   c.alu_ctrl = ALU_W'(10);
          default: c.alu_ctrl = ALU_W'(63);
        endcase
      end
      4'd9:  c.alu_ctrl = ALU_W'(11);
      4'd10: c.alu_ctrl = ALU_W'(12);
      4'd11: c.alu_mux = 1'b1;
      4'd12: begin
        c.sel_b    = 2'b01;
        c.mem_re   = 1'b1;
        c.sel_data = 1'b1;
        c.is_ld    = 1'b1;
      end
      4'd13: begin
        c.sel_b  = 2'b10;
        c.mem_we = 1'b1;
        c.reg_we = 1'b0;
      end
      4'd14: begin
        c.alu_ctrl = ALU_W'(14);
        c.is_bt    = 1'b1;
        c.reg_we   = 1'b0;
      end
      default: begin
        c.alu_ctrl = ALU_W'(14);
        c.reg_we   = 1'b0;
      end
    endcase
    return c;
  endfunction

  function automatic logic reads_a(input logic [3:0] op);
    return !(op == 4'd11 || op == 4'd14 || op == 4'd15);
  endfunction

  function automatic logic reads_b(input logic [3:0] op);
    return !(op == 4'd6 || op == 4'd11 || op == 4'd12 || op == 4'd14 || op == 4'd15);
  endfunction

  ctrl_t             dec, ctl_p0;
  logic              vld_p0, vld_p1, vld_p2;
  logic [REG_AW-1:0] rd_p0, rd_p1, rd_p2;
  logic              mem_we_p1, mem_re_p1, reg_we_p1, sel_data_p1;
  logic              reg_we_p2, sel_data_p2;
  logic [CNT_W-1:0]  mul_cnt;
  logic              load_use, mul_hold, take;

  assign dec      = decode(opcode, cmp_flag);
  assign re_a     = id_valid & reads_a(opcode);
  assign re_b     = id_valid & reads_b(opcode);
  assign load_use = vld_p0 & ctl_p0.is_ld &
                    ((re_a & (rd_p0 == id_ra)) | (re_b & (rd_p0 == id_rb)));
  assign mul_hold     = (mul_cnt != '0);
  assign branch_taken = vld_p0 & ctl_p0.is_bt & flag_q;
  assign id_ready     = !(load_use | mul_hold);
  // A flushed or stalled ID instruction becomes a bubble in EX.
  assign take         = id_valid & !load_use & !branch_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      ctl_p0      <= '0;
      rd_p0       <= '0;
      vld_p1      <= 1'b0;
      mem_we_p1   <= 1'b0;
      mem_re_p1   <= 1'b0;
      reg_we_p1   <= 1'b0;
      sel_data_p1 <= 1'b0;
      rd_p1       <= '0;
      vld_p2      <= 1'b0;
      reg_we_p2   <= 1'b0;
      sel_data_p2 <= 1'b0;
      rd_p2       <= '0;
      mul_cnt     <= '0;
      flag_q      <= 1'b0;
    end else begin
      // ID -> EX
      if (mul_hold) begin
        mul_cnt <= mul_cnt - CNT_ONE;
      end else begin
        vld_p0  <= take;
        ctl_p0  <= take ? dec : '0;
        rd_p0   <= take ? id_rd : '0;
        mul_cnt <= (take && opcode == 4'd2) ? MUL_INIT : '0;
      end
      if (vld_p0 && ctl_p0.is_cmp) flag_q <= cmp_result;
      // EX -> MEM
      vld_p1      <= vld_p0 & !mul_hold;
      mem_we_p1   <= ctl_p0.mem_we & vld_p0 & !mul_hold;
      mem_re_p1   <= ctl_p0.mem_re & vld_p0 & !mul_hold;
      reg_we_p1   <= ctl_p0.reg_we & vld_p0 & !mul_hold;
      sel_data_p1 <= ctl_p0.sel_data & vld_p0 & !mul_hold;
      rd_p1       <= mul_hold ? '0 : rd_p0;
      // MEM -> WB
      vld_p2      <= vld_p1;
      reg_we_p2   <= reg_we_p1;
      sel_data_p2 <= sel_data_p1;
      rd_p2       <= rd_p1;
    end
  end

  assign ex_valid    = vld_p0;
  assign ex_alu_ctrl = ctl_p0.alu_ctrl;
  assign ex_sel_b    = ctl_p0.sel_b;
  assign ex_alu_mux  = ctl_p0.alu_mux;
  assign ex_rd       = rd_p0;
  assign mem_valid   = vld_p1;
  assign mem_we      = mem_we_p1;
  assign mem_re      = mem_re_p1;
  assign mem_rd      = rd_p1;
  assign wb_valid    = vld_p2;
  assign wb_reg_we   = reg_we_p2;
  assign wb_sel_data = sel_data_p2;
  assign wb_rd       = rd_p2;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control (MUL_LAT=3): decode, stalls, MUL hold,
// branch flush and reset recovery against hand-computed expectations.
module tb_pipe_control;
  logic       clk, rst_n, id_valid, cmp_result;
  logic [3:0] opcode, id_ra, id_rb, id_rd;
  logic [1:0] cmp_flag;
  logic       id_ready, re_a, re_b, ex_valid, ex_alu_mux;
  logic [5:0] ex_alu_ctrl;
  logic [1:0] ex_sel_b;
  logic [3:0] ex_rd, mem_rd, wb_rd;
  logic       mem_valid, mem_we, mem_re, wb_valid, wb_reg_we, wb_sel_data;
  logic       branch_taken, flag_q;
  int         n_checks = 0;
  int         n_errors = 0;

  pipe_control #(.REG_AW(4), .ALU_W(6), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
    .cmp_flag(cmp_flag), .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .cmp_result(cmp_result), .id_ready(id_ready), .re_a(re_a), .re_b(re_b),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_sel_b(ex_sel_b),
    .ex_alu_mux(ex_alu_mux), .ex_rd(ex_rd), .mem_valid(mem_valid),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_reg_we(wb_reg_we), .wb_sel_data(wb_sel_data), .wb_rd(wb_rd),
    .branch_taken(branch_taken), .flag_q(flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one ID slot at the falling edge; checks follow 1 time unit later.
  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] f,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
    @(negedge clk);
    id_valid = v; opcode = op; cmp_flag = f; id_ra = ra; id_rb = rb; id_rd = rd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd15, 2'b00, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; opcode = 4'd15; cmp_flag = 2'b00;
    id_ra = '0; id_rb = '0; id_rd = '0; cmp_result = 1'b0;
    repeat (2) @(posedge clk);
    idle();
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_ex_ctrl", 32'(ex_alu_ctrl), 0);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_flag", 32'(flag_q), 0);
    check("rst_branch", 32'(branch_taken), 0);
    check("rst_id_ready", 32'(id_ready), 1);
    rst_n = 1'b1;

    // ADD r1,r2 -> r3
    drive(1'b1, 4'd0, 2'b00, 4'd1, 4'd2, 4'd3);
    check("add_re_a", 32'(re_a), 1);
    check("add_re_b", 32'(re_b), 1);
    check("add_ready", 32'(id_ready), 1);
    idle();
    check("add_ex_valid", 32'(ex_valid), 1);
    check("add_ex_ctrl", 32'(ex_alu_ctrl), 0);
    check("add_ex_rd", 32'(ex_rd), 3);
    idle();
    check("add_mem_valid", 32'(mem_valid), 1);
    check("add_mem_rd", 32'(mem_rd), 3);
    idle();
    check("add_wb_valid", 32'(wb_valid), 1);
    check("add_wb_we", 32'(wb_reg_we), 1);
    check("add_wb_rd", 32'(wb_rd), 3);
    check("bubble_ex_valid", 32'(ex_valid), 0);

    // LD r4 then ADD reading ra=4: one stall cycle
    drive(1'b1, 4'd12, 2'b00, 4'd1, 4'd0, 4'd4);
    check("ld_re_b", 32'(re_b), 0);
    drive(1'b1, 4'd0, 2'b00, 4'd4, 4'd2, 4'd5);
    check("lu_ex_sel_b", 32'(ex_sel_b), 1);
    check("lu_ready", 32'(id_ready), 0);
    drive(1'b1, 4'd0, 2'b00, 4'd4, 4'd2, 4'd5);
    check("lu_bubble", 32'(ex_valid), 0);
    check("lu_ready2", 32'(id_ready), 1);
    check("lu_mem_re", 32'(mem_re), 1);
    idle();
    check("lu_add_ex", 32'(ex_valid), 1);
    check("lu_add_rd", 32'(ex_rd), 5);
    check("ld_wb_sel", 32'(wb_sel_data), 1);
    check("ld_wb_rd", 32'(wb_rd), 4);
    idle();

    // LD r4 then ADD ra=5: no stall
    drive(1'b1, 4'd12, 2'b00, 4'd1, 4'd0, 4'd4);
    drive(1'b1, 4'd0, 2'b00, 4'd5, 4'd2, 4'd6);
    check("nolu_ready", 32'(id_ready), 1);
    idle();
    check("nolu_ex_rd", 32'(ex_rd), 6);

    // LD r4 then SUB rb=4 stalls; NOT rb=4 does not (rb unread)
    drive(1'b1, 4'd12, 2'b00, 4'd1, 4'd0, 4'd4);
    drive(1'b1, 4'd1, 2'b00, 4'd1, 4'd4, 4'd7);
    check("lu_rb_ready", 32'(id_ready), 0);
    idle();
    drive(1'b1, 4'd12, 2'b00, 4'd1, 4'd0, 4'd4);
    drive(1'b1, 4'd6, 2'b00, 4'd1, 4'd4, 4'd7);
    check("not_re_b", 32'(re_b), 0);
    check("not_ready", 32'(id_ready), 1);
    idle();
    check("not_ex_ctrl", 32'(ex_alu_ctrl), 6);
    idle(); idle();

    // MUL then SUB with MUL_LAT=3
    drive(1'b1, 4'd2, 2'b00, 4'd1, 4'd2, 4'd7);
    drive(1'b1, 4'd1, 2'b00, 4'd1, 4'd2, 4'd8);
    check("mul_ctrl_c1", 32'(ex_alu_ctrl), 2);
    check("mul_ready_c1", 32'(id_ready), 0);
    drive(1'b1, 4'd1, 2'b00, 4'd1, 4'd2, 4'd8);
    check("mul_ctrl_c2", 32'(ex_alu_ctrl), 2);
    check("mul_ready_c2", 32'(id_ready), 0);
    check("mul_mem_c2", 32'(mem_valid), 0);
    drive(1'b1, 4'd1, 2'b00, 4'd1, 4'd2, 4'd8);
    check("mul_ctrl_c3", 32'(ex_alu_ctrl), 2);
    check("mul_ready_c3", 32'(id_ready), 1);
    check("mul_mem_c3", 32'(mem_valid), 0);
    idle();
    check("sub_ex_ctrl", 32'(ex_alu_ctrl), 1);
    check("sub_ex_rd", 32'(ex_rd), 8);
    check("mul_mem_rd", 32'(mem_rd), 7);
    idle();
    check("mul_wb_rd", 32'(wb_rd), 7);
    check("sub_mem_rd", 32'(mem_rd), 8);
    idle(); idle();

    // CMP LE (true), BT, ADD: branch flushes ADD
    drive(1'b1, 4'd8, 2'b11, 4'd1, 4'd2, 4'd0);
    drive(1'b1, 4'd14, 2'b00, 4'd0, 4'd0, 4'd0);
    cmp_result = 1'b1;
    check("cmp_le_ctrl", 32'(ex_alu_ctrl), 10);
    check("cmp_flag_pre", 32'(flag_q), 0);
    drive(1'b1, 4'd0, 2'b00, 4'd1, 4'd2, 4'd9);
    cmp_result = 1'b0;
    check("bt_flag", 32'(flag_q), 1);
    check("bt_taken", 32'(branch_taken), 1);
    check("bt_ready", 32'(id_ready), 1);
    idle();
    check("bt_flushed", 32'(ex_valid), 0);
    check("bt_pulse_end", 32'(branch_taken), 0);
    idle(); idle();

    // Same with CMP false: no branch, ADD proceeds
    drive(1'b1, 4'd8, 2'b11, 4'd1, 4'd2, 4'd0);
    drive(1'b1, 4'd14, 2'b00, 4'd0, 4'd0, 4'd0);
    cmp_result = 1'b0;
    check("cmp_f_flag_pre", 32'(flag_q), 1);
    drive(1'b1, 4'd0, 2'b00, 4'd1, 4'd2, 4'd9);
    check("bt_nt_flag", 32'(flag_q), 0);
    check("bt_nt_taken", 32'(branch_taken), 0);
    idle();
    check("bt_nt_add_ex", 32'(ex_valid), 1);
    check("bt_nt_add_rd", 32'(ex_rd), 9);
    idle(); idle(); idle();

    // ST, CMP LT, BT, NOP: only ST writes memory, none write registers
    drive(1'b1, 4'd13, 2'b00, 4'd1, 4'd2, 4'd0);
    drive(1'b1, 4'd8, 2'b01, 4'd1, 4'd2, 4'd0);
    check("st_sel_b", 32'(ex_sel_b), 2);
    drive(1'b1, 4'd14, 2'b00, 4'd0, 4'd0, 4'd0);
    check("cmp_lt_ctrl", 32'(ex_alu_ctrl), 8);
    check("st_mem_we", 32'(mem_we), 1);
    drive(1'b1, 4'd15, 2'b00, 4'd0, 4'd0, 4'd0);
    check("nop_re_a", 32'(re_a), 0);
    check("cmp_mem_we", 32'(mem_we), 0);
    check("st_wb_valid", 32'(wb_valid), 1);
    check("st_wb_we", 32'(wb_reg_we), 0);
    idle();
    check("nop_ex_ctrl", 32'(ex_alu_ctrl), 14);
    check("nop_ex_valid", 32'(ex_valid), 1);
    check("bt_mem_we", 32'(mem_we), 0);
    check("cmp_wb_we", 32'(wb_reg_we), 0);
    idle();
    check("bt_wb_we", 32'(wb_reg_we), 0);
    idle();
    check("nop_wb_valid", 32'(wb_valid), 1);
    check("nop_wb_we", 32'(wb_reg_we), 0);

    // MOV and CMP NOP-mode decode; CMP EQ leaves flag_q=1 ahead of reset
    drive(1'b1, 4'd11, 2'b00, 4'd0, 4'd0, 4'd2);
    drive(1'b1, 4'd8, 2'b00, 4'd1, 4'd2, 4'd0);
    check("mov_mux", 32'(ex_alu_mux), 1);
    check("mov_ctrl", 32'(ex_alu_ctrl), 0);
    drive(1'b1, 4'd8, 2'b10, 4'd1, 4'd2, 4'd0);
    check("cmp_nop_ctrl", 32'(ex_alu_ctrl), 63);
    idle();
    cmp_result = 1'b1;
    check("cmp_eq_ctrl", 32'(ex_alu_ctrl), 9);
    idle();
    cmp_result = 1'b0;
    check("cmp_eq_flag", 32'(flag_q), 1);

    // Reset during MUL hold
    drive(1'b1, 4'd2, 2'b00, 4'd1, 4'd2, 4'd7);
    idle();
    check("rmul_ready", 32'(id_ready), 0);
    rst_n = 1'b0;
    idle();
    check("rmul_ex_valid", 32'(ex_valid), 0);
    check("rmul_ex_ctrl", 32'(ex_alu_ctrl), 0);
    check("rmul_ex_rd", 32'(ex_rd), 0);
    check("rmul_mem_valid", 32'(mem_valid), 0);
    check("rmul_wb_valid", 32'(wb_valid), 0);
    check("rmul_flag", 32'(flag_q), 0);
    rst_n = 1'b1;
    idle();
    check("rmul_ready_rel", 32'(id_ready), 1);
    check("rmul_ex_after", 32'(ex_valid), 0);

    // Reset during load-use stall
    drive(1'b1, 4'd12, 2'b00, 4'd1, 4'd0, 4'd4);
    drive(1'b1, 4'd0, 2'b00, 4'd4, 4'd2, 4'd5);
    check("rlu_ready", 32'(id_ready), 0);
    rst_n = 1'b0;
    idle();
    check("rlu_ex_valid", 32'(ex_valid), 0);
    check("rlu_mem_valid", 32'(mem_valid), 0);
    check("rlu_mem_re", 32'(mem_re), 0);
    check("rlu_mem_rd", 32'(mem_rd), 0);
    rst_n = 1'b1;
    idle();
    check("rlu_ready_rel", 32'(id_ready), 1);
    check("rlu_wb_valid", 32'(wb_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
